// File: rtl/encoder8x3_pend.sv
// Registered 8-to-3 priority encoder with sticky request capture.
// Requests latch into pend; the winning index is offered on y via valid/ready.
module encoder8x3_pend #(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] d,
   input  logic       clr,
   input  logic       ready,
   output logic [2:0] y,
   output logic       valid,
   output logic [7:0] pend,
   output logic       overrun
);

   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   state_t     state_reg, state_next;
   logic [7:0] pend_reg, pend_next;
   logic [2:0] y_reg, y_next;
   logic       overrun_reg, overrun_next;

   logic       ack;
   logic [7:0] ack_mask;
   logic [7:0] req_in;
   logic [7:0] hit;
   logic [2:0] prio_idx;
   logic       prio_any;

   assign ack    = valid & ready;
   assign req_in = en ? d : 8'h00;

   // Per-bit clear mask for the accepted index and per-bit overrun detection;
   // a re-request of the bit being accepted is not an overrun.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign ack_mask[gi] = ack && (y_reg == 3'(gi));
         assign hit[gi]      = req_in[gi] & pend_reg[gi] & ~ack_mask[gi];
      end
   endgenerate

   always_comb begin
      prio_idx = 3'd0;
      prio_any = |pend_reg;
      if (HIGH_FIRST) begin
         for (int i = 0; i < 8; i++)
            if (pend_reg[i]) prio_idx = 3'(i);
      end else begin
         for (int i = 7; i >= 0; i--)
            if (pend_reg[i]) prio_idx = 3'(i);
      end
   end

   always_comb begin
      pend_next    = (pend_reg & ~ack_mask) | req_in;
      overrun_next = overrun_reg | (|hit);
      y_next       = y_reg;
      if (clr) begin
         pend_next    = 8'h00;
         overrun_next = 1'b0;
      end else if (state_reg == IDLE && prio_any) begin
         y_next = prio_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (prio_any) state_next = PRESENT;
            PRESENT: if (ready)    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      valid = (state_reg == PRESENT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg    <= 8'h00;
         y_reg       <= 3'd0;
         overrun_reg <= 1'b0;
      end else begin
         pend_reg    <= pend_next;
         y_reg       <= y_next;
         overrun_reg <= overrun_next;
      end
   end

   assign y       = y_reg;
   assign pend    = pend_reg;
   assign overrun = overrun_reg;

endmodule
